key_event_decoder: RTL and testbench



---
 rtl/key_event_pkg.sv | 23 ++
 rtl/key_edge_det.sv | 21 ++
 rtl/key_event_decoder.sv | 143 ++++++++++++++
 tb/tb_key_event_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - state encoding and event bundle shared by button event consumers
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HELD,
    REPEAT,
    WAIT2,
    DONE
  } key_state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic shrt;
    logic lng;
    logic rep;
    logic dbl;
  } key_events_t;

  localparam key_events_t NO_EVENTS = '0;

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - rise/fall detector on a debounced level
module key_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic rise,
  output logic fall
);

  logic lvl_q;

  // Resetting to 1 means a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) lvl_q <= 1'b1;
    else        lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - decodes one debounced button level into one-cycle UI events
// Optional KEY_DOUBLE_CLICK_EN defers short_p to detect double-clicks.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int DCLICK_CYCLES = 15000000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic press_p,
  output logic release_p,
  output logic short_p,
  output logic long_p,
  output logic rep_p,
  output logic dbl_p,
  output logic held
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (longint'(LONG_CYCLES) < 2 || longint'(LONG_CYCLES) >= CNT_LIMIT) begin : g_bad_long
    $error("LONG_CYCLES out of range for CNT_W");
  end
  if (longint'(REPEAT_CYCLES) < 2 || longint'(REPEAT_CYCLES) >= CNT_LIMIT) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range for CNT_W");
  end
  if (longint'(DCLICK_CYCLES) < 2 || longint'(DCLICK_CYCLES) >= CNT_LIMIT) begin : g_bad_dclick
    $error("DCLICK_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`endif

  logic        rise, fall;
  key_state_t  state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  key_events_t ev_q, ev_d;
  logic        held_q;

  key_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  // A release always beats a threshold reached in the same cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ev_d    = NO_EVENTS;
    case (state)
      IDLE: begin
        if (rise) begin
          ev_d.press = 1'b1;
          cnt_d      = '0;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (fall) begin
          ev_d.rel = 1'b1;
`ifdef KEY_DOUBLE_CLICK_EN
          cnt_d    = '0;
          state_d  = WAIT2;
`else
          ev_d.shrt = 1'b1;
          state_d   = IDLE;
`endif
        end else if (cnt == LONG_LAST) begin
          ev_d.lng = 1'b1;
          cnt_d    = '0;
          state_d  = REPEAT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          ev_d.rel = 1'b1;
          state_d  = IDLE;
        end else if (cnt == REP_LAST) begin
          ev_d.rep = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef KEY_DOUBLE_CLICK_EN
      WAIT2: begin
        if (rise) begin
          ev_d.dbl   = 1'b1;
          ev_d.press = 1'b1;
          state_d    = DONE;
        end else if (cnt == DCLK_LAST) begin
          ev_d.shrt = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        if (fall) begin
          ev_d.rel = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ev_q   <= NO_EVENTS;
      held_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ev_q   <= ev_d;
      held_q <= (state_d == HELD) || (state_d == REPEAT);
    end
  end

  assign press_p   = ev_q.press;
  assign release_p = ev_q.rel;
  assign short_p   = ev_q.shrt;
  assign long_p    = ev_q.lng;
  assign rep_p     = ev_q.rep;
  assign dbl_p     = ev_q.dbl;
  assign held      = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed bench for key_event_decoder (LONG=8, REPEAT=4, DCLICK=6)
module tb_key_event_decoder;

`ifdef KEY_DOUBLE_CLICK_EN
  localparam int SD = 6;
`else
  localparam int SD = 0;
`endif

  logic clk, rst_n, lvl;
  logic press_p, release_p, short_p, long_p, rep_p, dbl_p, held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .DCLICK_CYCLES(6),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lvl      (lvl),
    .press_p  (press_p),
    .release_p(release_p),
    .short_p  (short_p),
    .long_p   (long_p),
    .rep_p    (rep_p),
    .dbl_p    (dbl_p),
    .held     (held)
  );

  int cyc, n_cmp, n_bad;
  int n_press, n_rel, n_short, n_long, n_rep, n_dbl, n_dbl_total;
  int t_press, t_rel, t_short, t_long, t_rep1, t_rep2, t_dbl;
  logic held_at_press;

  // Advance one clock and log every pulse seen just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_p)   begin n_press++; t_press = cyc; held_at_press = held; end
    if (release_p) begin n_rel++;   t_rel   = cyc; end
    if (short_p)   begin n_short++; t_short = cyc; end
    if (long_p)    begin n_long++;  t_long  = cyc; end
    if (rep_p)     begin n_rep++; if (n_rep == 1) t_rep1 = cyc; else t_rep2 = cyc; end
    if (dbl_p)     begin n_dbl++; n_dbl_total++; t_dbl = cyc; end
  endtask

  task automatic clear_log();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1; t_rep1 = -1; t_rep2 = -1; t_dbl = -1;
    held_at_press = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lvl = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({press_p, release_p, short_p, long_p, rep_p, dbl_p, held} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000000", {press_p, release_p, short_p, long_p, rep_p, dbl_p, held});
    end
    rst_n = 1'b1;
    clear_log();
    repeat (4) tick();
    lvl = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (n_press + n_rel + n_short + n_long + n_rep + n_dbl !== 0) begin
      n_bad++;
      $display("FAIL held_through_reset: got %0d pulses want 0", n_press + n_rel + n_short + n_long + n_rep + n_dbl);
    end
    lvl = 1'b1;
    tick();
    n_cmp++;
    if (press_p !== 1'b1 || held !== 1'b1) begin
      n_bad++;
      $display("FAIL first_press: got press=%b held=%b want 1 1", press_p, held);
    end
    lvl = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_short();
    int c;
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (3) tick();
    lvl = 1'b0; repeat (12) tick();
    n_cmp++;
    if (t_press !== c + 1 || held_at_press !== 1'b1) begin
      n_bad++; $display("FAIL short_press: got t=%0d held=%b want t=%0d held=1", t_press, held_at_press, c + 1);
    end
    n_cmp++;
    if (t_rel !== c + 4 || n_rel !== 1) begin
      n_bad++; $display("FAIL short_release: got t=%0d n=%0d want t=%0d n=1", t_rel, n_rel, c + 4);
    end
    n_cmp++;
    if (t_short !== c + 4 + SD || n_short !== 1) begin
      n_bad++; $display("FAIL short_pulse: got t=%0d n=%0d want t=%0d n=1", t_short, n_short, c + 4 + SD);
    end
    n_cmp++;
    if (n_long !== 0 || n_rep !== 0 || held !== 1'b0) begin
      n_bad++; $display("FAIL short_no_long: got long=%0d rep=%0d held=%b want 0 0 0", n_long, n_rep, held);
    end
  endtask

  task automatic test_long_repeat();
    int c;
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (20) tick();
    lvl = 1'b0; repeat (6) tick();
    n_cmp++;
    if (t_long !== c + 9 || n_long !== 1 || t_long - t_press !== 8) begin
      n_bad++; $display("FAIL long_pulse: got t=%0d n=%0d want t=%0d n=1", t_long, n_long, c + 9);
    end
    n_cmp++;
    if (t_rep1 !== c + 13 || t_rep2 !== c + 17 || n_rep !== 2) begin
      n_bad++; $display("FAIL repeat_pulses: got %0d,%0d n=%0d want %0d,%0d n=2", t_rep1, t_rep2, n_rep, c + 13, c + 17);
    end
    n_cmp++;
    if (t_rel !== c + 21 || n_rel !== 1 || n_short !== 0) begin
      n_bad++; $display("FAIL long_release: got t=%0d n=%0d short=%0d want t=%0d n=1 short=0", t_rel, n_rel, n_short, c + 21);
    end
  endtask

  task automatic test_boundaries();
    int c;
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (8) tick();
    lvl = 1'b0; repeat (10) tick();
    n_cmp++;
    if (n_long !== 0 || t_rel !== c + 9 || t_short !== c + 9 + SD) begin
      n_bad++; $display("FAIL fall_at_long: got long=%0d rel=%0d short=%0d want 0 %0d %0d", n_long, t_rel, t_short, c + 9, c + 9 + SD);
    end
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (12) tick();
    lvl = 1'b0; repeat (6) tick();
    n_cmp++;
    if (t_long !== c + 9 || t_rel !== c + 13) begin
      n_bad++; $display("FAIL fall_at_rep_times: got long=%0d rel=%0d want %0d %0d", t_long, t_rel, c + 9, c + 13);
    end
    n_cmp++;
    if (n_rep !== 0 || n_short !== 0 || n_rel !== 1) begin
      n_bad++; $display("FAIL fall_at_rep_pulses: got rep=%0d short=%0d rel=%0d want 0 0 1", n_rep, n_short, n_rel);
    end
  endtask

  task automatic test_reset_in_repeat();
    lvl = 1'b1; repeat (11) tick();
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++; $display("FAIL repeat_held: got %b want 1", held);
    end
    clear_log();
    rst_n = 1'b0; tick();
    n_cmp++;
    if ({press_p, release_p, short_p, long_p, rep_p, dbl_p, held} !== 7'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b want 0000000", {press_p, release_p, short_p, long_p, rep_p, dbl_p, held});
    end
    tick();
    rst_n = 1'b1; repeat (2) tick();
    lvl = 1'b0; repeat (10) tick();
    n_cmp++;
    if (n_press + n_rel + n_short + n_long + n_rep !== 0) begin
      n_bad++; $display("FAIL midreset_no_release: got %0d pulses want 0", n_press + n_rel + n_short + n_long + n_rep);
    end
  endtask

  task automatic test_double_click();
    int c;
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (2) tick();
    lvl = 1'b0; repeat (3) tick();
    lvl = 1'b1; repeat (2) tick();
    lvl = 1'b0; repeat (12) tick();
    n_cmp++;
    if (n_press !== 2 || n_rel !== 2 || t_press !== c + 6) begin
      n_bad++; $display("FAIL dclick_presses: got n=%0d rel=%0d t=%0d want 2 2 %0d", n_press, n_rel, t_press, c + 6);
    end
`ifdef KEY_DOUBLE_CLICK_EN
    n_cmp++;
    if (n_dbl !== 1 || t_dbl !== c + 6 || n_short !== 0) begin
      n_bad++; $display("FAIL dclick_pulse: got dbl=%0d t=%0d short=%0d want 1 %0d 0", n_dbl, t_dbl, n_short, c + 6);
    end
`else
    n_cmp++;
    if (n_dbl !== 0 || n_short !== 2 || t_short !== c + 8) begin
      n_bad++; $display("FAIL two_shorts: got dbl=%0d short=%0d t=%0d want 0 2 %0d", n_dbl, n_short, t_short, c + 8);
    end
`endif
  endtask

  task automatic test_single_click();
    int c;
    clear_log(); c = cyc;
    lvl = 1'b1; repeat (2) tick();
    lvl = 1'b0; repeat (10) tick();
    n_cmp++;
    if (t_rel !== c + 3 || t_short - t_rel !== SD || n_short !== 1 || n_dbl !== 0) begin
      n_bad++; $display("FAIL single_click: got rel=%0d short=%0d n=%0d dbl=%0d want %0d %0d 1 0",
                        t_rel, t_short, n_short, n_dbl, c + 3, c + 3 + SD);
    end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0; n_dbl_total = 0;
    clear_log();
    test_reset();
    test_short();
    test_long_repeat();
    test_boundaries();
    test_reset_in_repeat();
    test_double_click();
    test_single_click();
`ifndef KEY_DOUBLE_CLICK_EN
    n_cmp++;
    if (n_dbl_total !== 0) begin
      n_bad++; $display("FAIL dbl_tied_low: got %0d pulses want 0", n_dbl_total);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
